// File: rtl/nios_core_debug_ocimem_arbiter.sv
// OCI RAM arbiter: shares the single-port debug memory between the
// JTAG debug-slave strobes and the CPU debug_mem Avalon slave.
module nios_core_debug_ocimem_arbiter #(
  parameter int   ADDR_W     = 8,
  parameter int   DATA_W     = 32,
  parameter logic JTAG_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              jtag_addr_load,
  input  logic [ADDR_W-1:0] jtag_addr,
  input  logic              jtag_req_rd,
  input  logic              jtag_req_wr,
  input  logic [DATA_W-1:0] jtag_wdata,
  output logic [DATA_W-1:0] jtag_rdata,
  output logic              jtag_done,
  output logic              jtag_busy,
  output logic              jtag_overrun,
  input  logic              jtag_lock,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_writedata,
  output logic              cpu_waitrequest,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic              cpu_readdatavalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CPU_RD,
    S_JTAG_RD
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_jptr;
  logic                r_pend;
  logic                r_pend_we;
  logic [DATA_W-1:0]   r_pend_wdata;
  logic                r_last_jtag;
  logic                r_overrun;
  logic                r_wdone;
  logic [DATA_W-1:0]   r_cpu_rdata;
  logic [DATA_W-1:0]   r_jtag_rdata;

  logic w_idle;
  logic w_cpu_req;
  logic w_jtag_req;
  logic w_gnt_cpu;
  logic w_gnt_jtag;
  logic w_jstb;
  logic w_jblock;
  logic w_jacc;

  // Tie goes to the side opposite the one served last
  always_comb begin
    w_idle     = (r_state == S_IDLE);
    w_cpu_req  = w_idle & (cpu_read | cpu_write) & ~jtag_lock;
    w_jtag_req = w_idle & r_pend;
    w_gnt_jtag = w_jtag_req & (~w_cpu_req | ~r_last_jtag);
    w_gnt_cpu  = w_cpu_req & ~w_gnt_jtag;
    w_jstb     = jtag_req_rd | jtag_req_wr;
    w_jblock   = r_pend | (r_state == S_JTAG_RD);
    w_jacc     = w_jstb & ~w_jblock;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_gnt_cpu && !cpu_write)
          w_state_nxt = S_CPU_RD;
        else if (w_gnt_jtag && !r_pend_we)
          w_state_nxt = S_JTAG_RD;
      end
      S_CPU_RD:  w_state_nxt = S_IDLE;
      S_JTAG_RD: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_jptr       <= '0;
      r_pend       <= 1'b0;
      r_pend_we    <= 1'b0;
      r_pend_wdata <= '0;
      r_last_jtag  <= JTAG_FIRST;
      r_overrun    <= 1'b0;
      r_wdone      <= 1'b0;
    end else begin
      if (jtag_addr_load)
        r_jptr <= jtag_addr;
      else if (w_gnt_jtag)
        r_jptr <= r_jptr + ADDR_W'(1);

      if (w_jacc) begin
        r_pend       <= 1'b1;
        r_pend_we    <= jtag_req_wr;
        r_pend_wdata <= jtag_wdata;
      end else if (w_gnt_jtag) begin
        r_pend <= 1'b0;
      end

      // A dropped strobe wins over a same-cycle clear
      if (w_jstb && w_jblock)
        r_overrun <= 1'b1;
      else if (jtag_addr_load)
        r_overrun <= 1'b0;

      if (w_gnt_jtag)
        r_last_jtag <= 1'b1;
      else if (w_gnt_cpu)
        r_last_jtag <= 1'b0;

      r_wdone <= w_gnt_jtag & r_pend_we;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cpu_rdata  <= '0;
      r_jtag_rdata <= '0;
    end else begin
      if (r_state == S_CPU_RD)
        r_cpu_rdata <= mem_rdata;
      if (r_state == S_JTAG_RD)
        r_jtag_rdata <= mem_rdata;
    end
  end

  // Read data is forwarded in its valid cycle, then held
  always_comb begin
    mem_en            = 1'b0;
    mem_we            = 1'b0;
    mem_addr          = '0;
    mem_wdata         = '0;
    cpu_waitrequest   = ~w_gnt_cpu;
    cpu_readdatavalid = (r_state == S_CPU_RD);
    cpu_readdata      = r_cpu_rdata;
    jtag_rdata        = r_jtag_rdata;
    jtag_done         = r_wdone | (r_state == S_JTAG_RD);
    jtag_busy         = r_pend | (r_state == S_JTAG_RD);
    jtag_overrun      = r_overrun;
    if (r_state == S_CPU_RD)
      cpu_readdata = mem_rdata;
    if (r_state == S_JTAG_RD)
      jtag_rdata = mem_rdata;
    unique case (1'b1)
      w_gnt_cpu: begin
        mem_en    = 1'b1;
        mem_we    = cpu_write;
        mem_addr  = cpu_address;
        mem_wdata = cpu_writedata;
      end
      w_gnt_jtag: begin
        mem_en    = 1'b1;
        mem_we    = r_pend_we;
        mem_addr  = r_jptr;
        mem_wdata = r_pend_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nios_core_debug_ocimem_arbiter.sv
// Directed bench for the OCI RAM arbiter with a 1-cycle-latency
// RAM model; inputs driven on negedge, outputs sampled 1 time unit later.
module tb_nios_core_debug_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        jtag_addr_load;
  logic [7:0]  jtag_addr;
  logic        jtag_req_rd;
  logic        jtag_req_wr;
  logic [31:0] jtag_wdata;
  logic [31:0] jtag_rdata;
  logic        jtag_done;
  logic        jtag_busy;
  logic        jtag_overrun;
  logic        jtag_lock;
  logic        cpu_read;
  logic        cpu_write;
  logic [7:0]  cpu_address;
  logic [31:0] cpu_writedata;
  logic        cpu_waitrequest;
  logic [31:0] cpu_readdata;
  logic        cpu_readdatavalid;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] ram [256];
  int vec = 0;
  int errs = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  nios_core_debug_ocimem_arbiter #(
    .ADDR_W(8), .DATA_W(32), .JTAG_FIRST(1'b0)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .jtag_addr_load(jtag_addr_load), .jtag_addr(jtag_addr),
    .jtag_req_rd(jtag_req_rd), .jtag_req_wr(jtag_req_wr),
    .jtag_wdata(jtag_wdata), .jtag_rdata(jtag_rdata),
    .jtag_done(jtag_done), .jtag_busy(jtag_busy),
    .jtag_overrun(jtag_overrun), .jtag_lock(jtag_lock),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_address(cpu_address), .cpu_writedata(cpu_writedata),
    .cpu_waitrequest(cpu_waitrequest), .cpu_readdata(cpu_readdata),
    .cpu_readdatavalid(cpu_readdatavalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic clr();
    jtag_addr_load = 0; jtag_addr = 0; jtag_req_rd = 0;
    jtag_req_wr = 0; jtag_wdata = 0; cpu_read = 0;
    cpu_write = 0; cpu_address = 0; cpu_writedata = 0;
  endtask

  task automatic test_reset();
    clr(); jtag_lock = 0;
    repeat (3) @(negedge clk);
    #1;
    vec++; if (cpu_waitrequest !== 1'b1) begin errs++; $display("FAIL rst_wait got %b want 1", cpu_waitrequest); end
    vec++; if (mem_en !== 1'b0) begin errs++; $display("FAIL rst_mem_en got %b want 0", mem_en); end
    vec++; if (jtag_done !== 1'b0 || jtag_busy !== 1'b0 || jtag_overrun !== 1'b0) begin errs++; $display("FAIL rst_jtag_flags got %b%b%b want 000", jtag_done, jtag_busy, jtag_overrun); end
    vec++; if (jtag_rdata !== 32'h0 || cpu_readdata !== 32'h0 || cpu_readdatavalid !== 1'b0) begin errs++; $display("FAIL rst_data got %h %h %b want 0", jtag_rdata, cpu_readdata, cpu_readdatavalid); end
    @(negedge clk); reset_n = 1;
    @(negedge clk); clr(); jtag_req_rd = 1;
    @(negedge clk); clr(); #1;
    vec++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h00) begin errs++; $display("FAIL rst_rd_grant got en%b we%b a%h want en1 we0 a00", mem_en, mem_we, mem_addr); end
    @(negedge clk); #1;
    vec++; if (jtag_busy !== 1'b1 || jtag_done !== 1'b1) begin errs++; $display("FAIL rst_in_jtag_rd got busy%b done%b want 11", jtag_busy, jtag_done); end
    reset_n = 0; #1;
    vec++; if (jtag_done !== 1'b0 || jtag_busy !== 1'b0 || mem_en !== 1'b0 || cpu_waitrequest !== 1'b1) begin errs++; $display("FAIL rst_abort got done%b busy%b en%b wait%b want 0001", jtag_done, jtag_busy, mem_en, cpu_waitrequest); end
    vec++; if (jtag_rdata !== 32'h0) begin errs++; $display("FAIL rst_abort_rdata got %h want 0", jtag_rdata); end
    @(negedge clk); reset_n = 1;
    @(negedge clk); clr(); jtag_req_wr = 1; jtag_wdata = 32'hCAFE;
    @(negedge clk); clr(); #1;
    vec++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h00) begin errs++; $display("FAIL rst_jptr0 got en%b we%b a%h want en1 we1 a00", mem_en, mem_we, mem_addr); end
    @(negedge clk); #1;
    vec++; if (jtag_done !== 1'b1) begin errs++; $display("FAIL rst_wr_done got %b want 1", jtag_done); end
  endtask

  task automatic test_jtag_burst();
    @(negedge clk); clr(); jtag_addr_load = 1; jtag_addr = 8'h10;
    jtag_req_wr = 1; jtag_wdata = 32'hDEADBEEF;
    @(negedge clk); clr(); #1;
    vec++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h10 || mem_wdata !== 32'hDEADBEEF) begin errs++; $display("FAIL burst_w0 got en%b we%b a%h d%h want 1 1 10 deadbeef", mem_en, mem_we, mem_addr, mem_wdata); end
    vec++; if (jtag_busy !== 1'b1) begin errs++; $display("FAIL burst_busy got %b want 1", jtag_busy); end
    @(negedge clk); clr(); jtag_req_wr = 1; jtag_wdata = 32'h12345678; #1;
    vec++; if (jtag_done !== 1'b1 || mem_en !== 1'b0) begin errs++; $display("FAIL burst_done0 got done%b en%b want 1 0", jtag_done, mem_en); end
    @(negedge clk); clr(); #1;
    vec++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h11 || mem_wdata !== 32'h12345678) begin errs++; $display("FAIL burst_w1 got en%b we%b a%h d%h want 1 1 11 12345678", mem_en, mem_we, mem_addr, mem_wdata); end
    @(negedge clk); clr(); jtag_addr_load = 1; jtag_addr = 8'h10; jtag_req_rd = 1; #1;
    vec++; if (jtag_done !== 1'b1) begin errs++; $display("FAIL burst_done1 got %b want 1", jtag_done); end
    @(negedge clk); clr(); #1;
    vec++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h10) begin errs++; $display("FAIL burst_rd got en%b we%b a%h want 1 0 10", mem_en, mem_we, mem_addr); end
    @(negedge clk); #1;
    vec++; if (jtag_done !== 1'b1 || jtag_rdata !== 32'hDEADBEEF) begin errs++; $display("FAIL burst_rdata got done%b %h want 1 deadbeef", jtag_done, jtag_rdata); end
    @(negedge clk); #1;
    vec++; if (jtag_done !== 1'b0 || jtag_busy !== 1'b0 || jtag_rdata !== 32'hDEADBEEF) begin errs++; $display("FAIL burst_hold got done%b busy%b %h want 0 0 deadbeef", jtag_done, jtag_busy, jtag_rdata); end
  endtask

  task automatic test_tie();
    @(negedge clk); clr(); jtag_addr_load = 1; jtag_addr = 8'h10; jtag_req_rd = 1;
    @(negedge clk); clr(); cpu_read = 1; cpu_address = 8'h11; #1;
    vec++; if (cpu_waitrequest !== 1'b0 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h11) begin errs++; $display("FAIL tie_cpu_gnt got wait%b en%b we%b a%h want 0 1 0 11", cpu_waitrequest, mem_en, mem_we, mem_addr); end
    @(negedge clk); clr(); #1;
    vec++; if (cpu_readdatavalid !== 1'b1 || cpu_readdata !== 32'h12345678 || mem_en !== 1'b0) begin errs++; $display("FAIL tie_cpu_data got v%b %h en%b want 1 12345678 0", cpu_readdatavalid, cpu_readdata, mem_en); end
    @(negedge clk); #1;
    vec++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h10 || cpu_readdatavalid !== 1'b0) begin errs++; $display("FAIL tie_jtag_gnt got en%b we%b a%h v%b want 1 0 10 0", mem_en, mem_we, mem_addr, cpu_readdatavalid); end
    @(negedge clk); #1;
    vec++; if (jtag_done !== 1'b1 || jtag_rdata !== 32'hDEADBEEF) begin errs++; $display("FAIL tie_jtag_data got done%b %h want 1 deadbeef", jtag_done, jtag_rdata); end
  endtask

  task automatic test_wrap();
    @(negedge clk); clr(); jtag_addr_load = 1; jtag_addr = 8'hFF; jtag_req_wr = 1; jtag_wdata = 32'hA1;
    @(negedge clk); clr(); #1;
    vec++; if (mem_en !== 1'b1 || mem_addr !== 8'hFF) begin errs++; $display("FAIL wrap_ff got en%b a%h want 1 ff", mem_en, mem_addr); end
    @(negedge clk); clr(); jtag_req_wr = 1; jtag_wdata = 32'hB2;
    @(negedge clk); clr(); #1;
    vec++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h00) begin errs++; $display("FAIL wrap_00 got en%b we%b a%h want 1 1 00", mem_en, mem_we, mem_addr); end
    @(negedge clk); clr(); jtag_req_rd = 1;
    @(negedge clk); clr(); #1;
    vec++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h01) begin errs++; $display("FAIL wrap_jptr got en%b we%b a%h want 1 0 01", mem_en, mem_we, mem_addr); end
    @(negedge clk); #1;
    vec++; if (jtag_rdata !== 32'h0) begin errs++; $display("FAIL wrap_rdata got %h want 0", jtag_rdata); end
  endtask

  task automatic test_overrun();
    @(negedge clk); clr(); jtag_req_rd = 1;
    @(negedge clk); clr(); jtag_req_rd = 1;
    cpu_write = 1; cpu_address = 8'h20; cpu_writedata = 32'hA5; #1;
    vec++; if (cpu_waitrequest !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 8'h20) begin errs++; $display("FAIL ovr_cpu0 got wait%b we%b a%h want 0 1 20", cpu_waitrequest, mem_we, mem_addr); end
    @(negedge clk); clr(); cpu_write = 1; cpu_address = 8'h21; cpu_writedata = 32'h5A; #1;
    vec++; if (jtag_overrun !== 1'b1) begin errs++; $display("FAIL ovr_flag got %b want 1", jtag_overrun); end
    vec++; if (cpu_waitrequest !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h02) begin errs++; $display("FAIL ovr_jtag_gnt got wait%b en%b we%b a%h want 1 1 0 02", cpu_waitrequest, mem_en, mem_we, mem_addr); end
    @(negedge clk); #1;
    vec++; if (cpu_waitrequest !== 1'b1 || mem_en !== 1'b0 || jtag_done !== 1'b1) begin errs++; $display("FAIL ovr_inflight got wait%b en%b done%b want 1 0 1", cpu_waitrequest, mem_en, jtag_done); end
    @(negedge clk); #1;
    vec++; if (cpu_waitrequest !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 8'h21) begin errs++; $display("FAIL ovr_cpu1 got wait%b we%b a%h want 0 1 21", cpu_waitrequest, mem_we, mem_addr); end
    @(negedge clk); clr(); #1;
    vec++; if (mem_en !== 1'b0 || jtag_busy !== 1'b0 || jtag_done !== 1'b0) begin errs++; $display("FAIL ovr_single got en%b busy%b done%b want 0 0 0", mem_en, jtag_busy, jtag_done); end
    @(negedge clk); clr(); jtag_addr_load = 1; jtag_addr = 8'h40;
    @(negedge clk); clr(); #1;
    vec++; if (jtag_overrun !== 1'b0) begin errs++; $display("FAIL ovr_clear got %b want 0", jtag_overrun); end
  endtask

  task automatic test_lock();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); clr(); jtag_lock = 1;
      cpu_write = 1; cpu_address = 8'h30; cpu_writedata = 32'h77; #1;
      vec++; if (cpu_waitrequest !== 1'b1 || mem_en !== 1'b0) begin errs++; $display("FAIL lock_hold%0d got wait%b en%b want 1 0", i, cpu_waitrequest, mem_en); end
    end
    @(negedge clk); jtag_lock = 0; #1;
    vec++; if (cpu_waitrequest !== 1'b0 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h30 || mem_wdata !== 32'h77) begin errs++; $display("FAIL lock_release got wait%b en%b we%b a%h d%h want 0 1 1 30 77", cpu_waitrequest, mem_en, mem_we, mem_addr, mem_wdata); end
    @(negedge clk); clr(); #1;
    vec++; if (ram[8'h30] !== 32'h77 || mem_en !== 1'b0) begin errs++; $display("FAIL lock_ram got %h en%b want 77 0", ram[8'h30], mem_en); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    mem_rdata = 32'h0;
    test_reset();
    test_jtag_burst();
    test_tie();
    test_wrap();
    test_overrun();
    test_lock();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
